queue_reg: RTL and testbench
============================

# queue_reg

First-in/first-out counterpart to the register-file stack: a 16-bit, DEPTH-entry register queue with the same `load`/`read` strobe interface. The oldest entry is always presented on `data_out`. Used where the Synapse core hands values to a consumer that must see them in arrival order, such as queued commands to a peripheral or a deferred-write buffer. Occupancy and full/empty status are explicit. Optional sticky overflow/underflow flags are available for firmware diagnostics.

## Interface
Parameters:
- DEPTH, 8, number of 16-bit entries; must be a power of two, 2 to 64.

Ports:
- sysclk  input  1  system clock; all state changes on rising edge.
- sysreset  input  1  asynchronous, active-low reset (asserted at 0); clears all state immediately.
- data_in  input  16  value written on `load`.
- load  input  1  single-cycle push strobe.
- read  input  1  single-cycle pop strobe; advances past the current head.
- data_out  output  16  current head (oldest entry); 16'h0000 when empty.
- count  output  $clog2(DEPTH)+1  number of valid entries, 0 to DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- err_clear  input  1  clears sticky error flags (see Configuration).
- overflow  output  1  sticky: a load was dropped because the queue was full.
- underflow  output  1  sticky: a read arrived while the queue was empty.

## Operation
- Storage is a circular buffer of DEPTH x 16 registers with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits wide. Pointers wrap modulo DEPTH with natural binary rollover.
- `count` is held in a register, not derived from the pointers, so that full and empty are distinguishable.
- `data_out` = `mem[rp]` when count != 0; otherwise 0. The output is combinational from registers, with no pipeline stage.
- Per-edge behaviour by (load, read, state):
  - load only, not full: `mem[wp]` <= data_in; wp+1; count+1.
  - load only, full: write dropped; pointers and count unchanged; overflow event.
  - read only, not empty: rp+1; count-1. The vacated entry is not cleared.
  - read only, empty: ignored; underflow event.
  - load and read, not empty and not full: write at wp and advance at rp; count unchanged.
  - load and read, full: both accepted (the pop frees a slot); count stays DEPTH; no overflow.
  - load and read, empty: load accepted, read ignored; count becomes 1; underflow event.
- empty and full are derived combinationally from `count`.
- Reset: wp, rp and count are set to 0; empty=1; full=0; data_out=0; overflow=0 and underflow=0. Storage contents need not be cleared. Reset asserted mid-operation discards all queued data. The first edge after release behaves as if the queue is empty.

## Timing
- Push-to-visibility: when the queue is empty, a load at edge N makes data_out = data_in starting just after edge N, so it can be read in cycle N+1.
- When the queue is not empty, a push does not change data_out.
- Pop: a read at edge N makes the next-oldest value appear on data_out after edge N.
- count, empty, full, overflow and underflow all update on the same edge as the triggering strobe.
- Back-to-back strobes every cycle are supported. There is no handshake; the producer must check `full` and the consumer must check `empty`.
- err_clear takes effect on the edge where it is sampled high. If an error event occurs in that same cycle, the flag is set (set wins over clear).

## Configuration
- QUEUE_REG_ERR_FLAGS_EN defined: overflow and underflow are sticky registers, set by the events listed above and cleared by err_clear or reset.
- QUEUE_REG_ERR_FLAGS_EN undefined: overflow and underflow are tied to 0 and err_clear is ignored. Port list is identical in both builds; queue data behaviour is identical in both builds.

## Test plan
- Reset then fill: release reset, push 16'h1111..16'h8888 on 8 consecutive cycles -> count steps 1..8; full=1 after the 8th edge; data_out=16'h1111 throughout.
- Drain order: from full, pop 8 times -> data_out sequence 1111, 2222, ... 8888, then 0; empty=1; count=0.
- Wrap-around: push 5, pop 5, push 6 -> data_out=the first of the new 6; count=6 with the pointers having wrapped past DEPTH-1.
- Simultaneous load+read: on empty, load=read=1 with 16'hABCD -> count=1, data_out=ABCD, underflow=1 (macro on). On full, load=read=1 -> count stays 8, head advances, overflow stays 0.
- Overflow/clear: on full, push 16'hDEAD -> dropped, contents unchanged, overflow=1. Pulse err_clear -> overflow=0. With the macro off -> overflow stays 0 throughout.
- Async reset mid-stream: with 3 entries queued, drive sysreset low between clock edges -> count=0, empty=1, data_out=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/queue_reg.sv
// queue_reg: 16-bit, DEPTH-entry register FIFO with load/read strobes.
// Define QUEUE_REG_ERR_FLAGS_EN for sticky overflow/underflow flags.
module queue_reg #(
    parameter int DEPTH = 8
) (
    input  logic                     sysclk,
    input  logic                     sysreset,
    input  logic [15:0]              data_in,
    input  logic                     load,
    input  logic                     read,
    output logic [15:0]              data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    input  logic                     err_clear,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          push;
    logic          pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop on a full queue frees the slot the simultaneous push needs.
    assign pop  = read & ~empty;
    assign push = load & (~full | read);

    assign data_out = empty ? 16'h0000 : mem[rp];

    // Storage write; contents are never cleared, count marks validity.
    always_ff @(posedge sysclk) begin
        if (push) begin
            mem[wp] <= data_in;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef QUEUE_REG_ERR_FLAGS_EN
    logic ovf_evt;
    logic unf_evt;

    assign ovf_evt = load & full & ~read;
    assign unf_evt = read & empty;

    // Sticky diagnostic flags; a new event wins over err_clear.
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (err_clear) begin
                overflow <= 1'b0;
            end
            if (unf_evt) begin
                underflow <= 1'b1;
            end else if (err_clear) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clear;

    assign unused_err_clear = err_clear;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_queue_reg.sv
// tb_queue_reg: table vectors, corner sequences and random traffic
// checked against a queue-based reference model.
module tb_queue_reg;

    localparam int DEPTH = 8;

`ifdef QUEUE_REG_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        sysclk;
    logic        sysreset;
    logic [15:0] data_in;
    logic        load;
    logic        read;
    logic [15:0] data_out;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        err_clear;
    logic        overflow;
    logic        underflow;

    queue_reg #(.DEPTH(DEPTH)) dut (
        .sysclk    (sysclk),
        .sysreset  (sysreset),
        .data_in   (data_in),
        .load      (load),
        .read      (read),
        .data_out  (data_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .err_clear (err_clear),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] q[$];
    bit          m_ovf;
    bit          m_unf;

    typedef struct {
        logic        ld;
        logic        rd;
        logic [15:0] din;
        int          e_cnt;
        logic [15:0] e_out;
        logic        e_full;
        logic        e_empty;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic mcheck();
        logic [15:0] head;
        head = (q.size() == 0) ? 16'h0000 : q[0];
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("data_out", 32'(data_out), 32'(head));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic cyc(input logic ld, input logic rd,
                       input logic [15:0] din, input logic clr);
        int pre;
        bit ov;
        bit un;
        @(negedge sysclk);
        load      = ld;
        read      = rd;
        data_in   = din;
        err_clear = clr;
        @(posedge sysclk);
        pre = q.size();
        un  = rd && (pre == 0);
        if (rd && pre > 0) begin
            void'(q.pop_front());
        end
        ov = 1'b0;
        if (ld) begin
            if (q.size() < DEPTH) q.push_back(din);
            else ov = 1'b1;
        end
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (ERR_EN && ov) m_ovf = 1'b1;
        if (ERR_EN && un) m_unf = 1'b1;
        #1;
        mcheck();
        load      = 1'b0;
        read      = 1'b0;
        err_clear = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i].ld      = 1'b1;
            tbl[i].rd      = 1'b0;
            tbl[i].din     = 16'(16'h1111 * (i + 1));
            tbl[i].e_cnt   = i + 1;
            tbl[i].e_out   = 16'h1111;
            tbl[i].e_full  = (i == 7);
            tbl[i].e_empty = 1'b0;
        end
        for (int j = 1; j <= 9; j++) begin
            tbl[7 + j].ld      = 1'b0;
            tbl[7 + j].rd      = 1'b1;
            tbl[7 + j].din     = 16'h0000;
            tbl[7 + j].e_cnt   = (j <= 8) ? 8 - j : 0;
            tbl[7 + j].e_out   = (j < 8) ? 16'(16'h1111 * (j + 1)) : 16'h0000;
            tbl[7 + j].e_full  = 1'b0;
            tbl[7 + j].e_empty = (j >= 8);
        end

        sysreset  = 1'b0;
        load      = 1'b0;
        read      = 1'b0;
        data_in   = 16'h0000;
        err_clear = 1'b0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        mcheck();
        @(negedge sysclk);
        sysreset = 1'b1;

        // Fill then drain, with one extra read on empty.
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].ld, tbl[i].rd, tbl[i].din, 1'b0);
            chk("tbl_count", 32'(count), 32'(tbl[i].e_cnt));
            chk("tbl_out", 32'(data_out), 32'(tbl[i].e_out));
            chk("tbl_full", 32'(full), 32'(tbl[i].e_full));
            chk("tbl_empty", 32'(empty), 32'(tbl[i].e_empty));
        end
        chk("drain_unf", 32'(underflow), 32'(ERR_EN));
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);

        // Wrap-around: push 5, pop 5, push 6.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'(16'h0500 + i), 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 16'(16'h0A00 + i), 1'b0);
        chk("wrap_head", 32'(data_out), 32'h0A00);
        chk("wrap_count", 32'(count), 32'd6);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 16'h0000, 1'b0);

        // Load+read on empty.
        cyc(1'b1, 1'b1, 16'hABCD, 1'b0);
        chk("lr_empty_cnt", 32'(count), 32'd1);
        chk("lr_empty_out", 32'(data_out), 32'hABCD);
        chk("lr_empty_unf", 32'(underflow), 32'(ERR_EN));
        cyc(1'b0, 1'b1, 16'h0000, 1'b1);
        chk("unf_cleared", 32'(underflow), 32'd0);

        // Full queue: load+read, overflow, clear, set-wins-over-clear.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 16'(16'hB000 + i), 1'b0);
        cyc(1'b1, 1'b1, 16'hC000, 1'b0);
        chk("lr_full_cnt", 32'(count), 32'd8);
        chk("lr_full_head", 32'(data_out), 32'hB001);
        chk("lr_full_ovf", 32'(overflow), 32'd0);
        cyc(1'b1, 1'b0, 16'hDEAD, 1'b0);
        chk("ovf_set", 32'(overflow), 32'(ERR_EN));
        chk("ovf_head", 32'(data_out), 32'hB001);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("ovf_clear", 32'(overflow), 32'd0);
        cyc(1'b1, 1'b0, 16'hBEEF, 1'b1);
        chk("set_wins", 32'(overflow), 32'(ERR_EN));
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 16'h0000, 1'b0);

        // Asynchronous reset between edges with 3 entries queued.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'(16'h3300 + i), 1'b0);
        #2;
        sysreset = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_empty", 32'(empty), 32'd1);
        chk("areset_out", 32'(data_out), 32'd0);
        @(negedge sysclk);
        sysreset = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);

        // Random traffic in load-heavy, read-heavy and balanced phases.
        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < 1000; k++) begin
                int pl;
                int pr;
                pl = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
                pr = 100 - pl;
                cyc(logic'($urandom_range(0, 99) < pl),
                    logic'($urandom_range(0, 99) < pr),
                    16'($urandom),
                    logic'($urandom_range(0, 19) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
